// File: rtl/processor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : processor_pkg
// Purpose  : Shared opcode, FSM state and ALU-select definitions for the
//            control unit and its sub-modules.
// Revision : 1.0 - initial release
// ============================================================================
package processor_pkg;

  // Instruction opcodes, carried in IR[15:12]
  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_e;

  // FSM states; the encoding is what State_out exposes for debug
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  // ALU operation selects
  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
// Module   : pc_counter
// Purpose  : Program counter with synchronous reset and increment enable.
//            Wraps naturally from 2^PC_W-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pc_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next PC: advance by one when enabled; overflow wraps to zero
  always_comb begin
    pc_d = pc_q;
    if (inc_i) pc_d = pc_q + PC_W'(1);
  end

  // PC register with synchronous reset to address 0
  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Multi-cycle control FSM for a small load/store processor.
//            Fetches from a synchronous ROM, decodes IR[15:12] and drives
//            datapath controls from the current state and IR only.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
  import processor_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic            Clk,
  input  logic            Rst,
  output logic [PC_W-1:0] IM_addr,
  input  logic [15:0]     IM_data,
  output logic [7:0]      D_addr,
  output logic            D_wr,
  output logic            MuxSel,
  output logic [2:0]      ALU_s,
  output logic [3:0]      RF_A_Addr,
  output logic [3:0]      RF_B_Addr,
  output logic            RFWen,
  output logic [3:0]      RFWAddr,
  output logic [PC_W-1:0] PC_out,
  output logic [15:0]     IR_out,
  output logic [3:0]      State_out
);

  state_e          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic            pc_inc;
  logic [PC_W-1:0] pc;
  logic            d_wr_raw;
  logic            rf_wen_raw;

  pc_counter #(.PC_W(PC_W)) u_pc (
    .clk_i (Clk),
    .rst_i (Rst),
    .inc_i (pc_inc),
    .pc_o  (pc)
  );

  // State and instruction register update
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; DECODE branches on the fresh ROM word, not the old IR
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_inc  = 1'b0;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        pc_inc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d = IM_data;
        case (IM_data[15:12])
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Datapath controls decoded from state and IR only
  always_comb begin
    D_addr     = 8'h00;
    d_wr_raw   = 1'b0;
    MuxSel     = 1'b0;
    ALU_s      = ALU_NONE;
    RF_A_Addr  = 4'h0;
    RF_B_Addr  = 4'h0;
    rf_wen_raw = 1'b0;
    RFWAddr    = 4'h0;
    case (state_q)
      S_STORE: begin
        D_addr    = ir_q[11:4];
        RF_A_Addr = ir_q[3:0];
        d_wr_raw  = 1'b1;
      end
      S_LOAD_A: begin
        D_addr = ir_q[11:4];
      end
      S_LOAD_B: begin
        D_addr     = ir_q[11:4];
        MuxSel     = 1'b0;
        RFWAddr    = ir_q[3:0];
        rf_wen_raw = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_A_Addr  = ir_q[11:8];
        RF_B_Addr  = ir_q[7:4];
        ALU_s      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
        MuxSel     = 1'b1;
        RFWAddr    = ir_q[3:0];
        rf_wen_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates the write strobes immediately so an interrupted
  // instruction never commits a write
  assign D_wr  = d_wr_raw & ~Rst;
  assign RFWen = rf_wen_raw & ~Rst;

  assign IM_addr   = pc;
  assign PC_out    = pc;
  assign IR_out    = ir_q;
  assign State_out = state_q;

endmodule
`default_nettype wire
